rgmii_receive_controller: RTL and testbench

RGMII_RECEIVE_CONTROLLER -- requirements
Module: rgmii_receive_controller

---
 rtl/rgmii_receive_controller_pkg.sv | 15 +
 rtl/rgmii_receive_controller.sv | 145 ++++++++++++++
 tb/tb_rgmii_receive_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_receive_controller_pkg.sv
// Shared definitions for the RGMII receive path: FSM states and the
// framing bytes that delimit the start of an Ethernet frame.
package rgmii_package;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        DISCARD  = 2'd3
    } rx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/rgmii_receive_controller.sv
// RGMII receive framer: strips preamble/SFD, streams payload bytes with a
// one-byte lookahead so the final byte carries out_last, and counts frames.
module rgmii_receive_controller
    import rgmii_package::*;
#(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  ddr_data,
    input  logic [1:0]  ddr_control,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_error,
    output logic [31:0] frame_count,
    output logic [31:0] error_count,
    output rx_state_e   debug_state
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);

    // Stream semantics: out_valid alone qualifies a beat. There is no ready;
    // the sink must accept every beat in the cycle it is presented.

    logic [7:0]  rx_data_q;
    logic        rx_dv_q;
    logic        rx_er_q;
    logic        primed_q;
    logic        armed_q;
    rx_state_e   state_q, state_d;
    logic [15:0] byte_count_q, byte_count_d;
    logic        frame_error_q, frame_error_d;
    logic [7:0]  pending_q, pending_d;
    logic        beat, beat_last, beat_error;
    logic        count_good, count_bad;

    // The rising nibble is the low half of the byte. primed_q marks that the
    // capture register holds real line data, so its reset value cannot arm us.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q <= 8'h00;
            rx_dv_q   <= 1'b0;
            rx_er_q   <= 1'b0;
            primed_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            rx_data_q <= {ddr_data[3:0], ddr_data[7:4]};
            rx_dv_q   <= ddr_control[1];
            rx_er_q   <= ddr_control[1] ^ ddr_control[0];
            primed_q  <= 1'b1;
            if (primed_q && !rx_dv_q) armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_count_d  = byte_count_q;
        frame_error_d = frame_error_q;
        pending_d     = pending_q;
        beat          = 1'b0;
        beat_last     = 1'b0;
        beat_error    = 1'b0;
        count_bad     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_dv_q && armed_q)
                    state_d = (rx_er_q || rx_data_q != PREAMBLE_BYTE) ? DISCARD : PREAMBLE;
            end
            PREAMBLE: begin
                if (!rx_dv_q) begin
                    state_d = IDLE;
                end else if (rx_er_q) begin
                    state_d = DISCARD;
                end else if (rx_data_q == SFD_BYTE) begin
                    state_d       = PAYLOAD;
                    byte_count_d  = 16'd0;
                    frame_error_d = 1'b0;
                end else if (rx_data_q != PREAMBLE_BYTE) begin
                    state_d = DISCARD;
                end
            end
            PAYLOAD: begin
                // The held byte is released once the next sample shows whether it was the last.
                if (!rx_dv_q) begin
                    state_d = IDLE;
                    if (byte_count_q == 16'd0) begin
                        count_bad = 1'b1;
                    end else begin
                        beat       = 1'b1;
                        beat_last  = 1'b1;
                        beat_error = frame_error_q || (byte_count_q < MIN_LEN);
                    end
                end else if (byte_count_q == MAX_LEN) begin
                    state_d    = DISCARD;
                    beat       = 1'b1;
                    beat_last  = 1'b1;
                    beat_error = 1'b1;
                end else begin
                    beat         = (byte_count_q != 16'd0);
                    pending_d    = rx_data_q;
                    byte_count_d = byte_count_q + 16'd1;
                    if (rx_er_q) frame_error_d = 1'b1;
                end
            end
            DISCARD: begin
                if (!rx_dv_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        count_good = beat_last && !beat_error;
        if (beat_last && beat_error) count_bad = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            byte_count_q  <= 16'd0;
            frame_error_q <= 1'b0;
            pending_q     <= 8'h00;
            out_data      <= 8'h00;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_error     <= 1'b0;
            frame_count   <= 32'd0;
            error_count   <= 32'd0;
        end else begin
            state_q       <= state_d;
            byte_count_q  <= byte_count_d;
            frame_error_q <= frame_error_d;
            pending_q     <= pending_d;
            out_valid     <= beat;
            out_last      <= beat_last;
            out_error     <= beat_error;
            if (beat) out_data <= pending_q;
            if (count_good) frame_count <= frame_count + 32'd1;
            if (count_bad)  error_count <= error_count + 32'd1;
        end
    end

    assign debug_state = state_q;

endmodule

// File: tb/tb_rgmii_receive_controller.sv
// Bench for rgmii_receive_controller: directed framing scenarios plus random
// frames checked against a frame-level model of the expected beats.
module tb_rgmii_receive_controller;
    import rgmii_package::*;

    localparam int MIN_B = 64;
    localparam int MAX_B = 100;

    logic        clock;
    logic        reset_n;
    logic [7:0]  ddr_data;
    logic [1:0]  ddr_control;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_error;
    logic [31:0] frame_count;
    logic [31:0] error_count;
    rx_state_e   debug_state;

    rgmii_receive_controller #(.MIN_FRAME_BYTES(MIN_B), .MAX_FRAME_BYTES(MAX_B)) dut (
        .clock(clock), .reset_n(reset_n), .ddr_data(ddr_data), .ddr_control(ddr_control),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_error(out_error),
        .frame_count(frame_count), .error_count(error_count), .debug_state(debug_state)
    );

    // Beat word: {cycle seen, last, error, data}
    logic [41:0] exp_q[$];
    logic [41:0] obs_q[$];
    logic [7:0]  payload[$];
    int          drive_cyc[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          stray = 0;
    int unsigned cyc = 0;
    int          last_drive_cyc = 0;
    int          exp_frames = 0;
    int          exp_errors = 0;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (out_valid) obs_q.push_back({cyc, out_last, out_error, out_data});
        else if (out_last || out_error) stray++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_byte(input logic dv, input logic er, input logic [7:0] b);
        @(negedge clock);
        ddr_data       = {b[3:0], b[7:4]};
        ddr_control    = {dv, dv ^ er};
        last_drive_cyc = int'(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_byte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_start(input int n_pre);
        for (int i = 0; i < n_pre; i++) drive_byte(1'b1, 1'b0, PREAMBLE_BYTE);
        drive_byte(1'b1, 1'b0, SFD_BYTE);
    endtask

    // Reference: a frame of n bytes yields min(n, MAX) beats, 3 cycles after each
    // byte; the last beat is flagged bad on truncation, short length or rx_er.
    function automatic void model_frame(input int er_idx);
        int   n;
        int   k;
        logic bad;
        n = payload.size();
        if (n == 0) begin
            exp_errors++;
            return;
        end
        k   = (n > MAX_B) ? MAX_B : n;
        bad = (n > MAX_B) || (k < MIN_B) || (er_idx >= 0 && er_idx < k);
        for (int i = 0; i < k; i++)
            exp_q.push_back({32'(drive_cyc[i] + 3), (i == k - 1), (i == k - 1) && bad, payload[i]});
        if (bad) exp_errors++;
        else     exp_frames++;
    endfunction

    task automatic send_frame(input int n_pre, input int er_idx);
        drive_cyc.delete();
        frame_start(n_pre);
        for (int i = 0; i < payload.size(); i++) begin
            drive_byte(1'b1, (i == er_idx), payload[i]);
            drive_cyc.push_back(last_drive_cyc);
        end
        idle(6);
        model_frame(er_idx);
    endtask

    task automatic send_garbage(input int kind);
        int n_pre;
        n_pre = $urandom_range(1, 5);
        for (int i = 0; i < n_pre; i++)
            drive_byte(1'b1, (kind == 2 && i == n_pre - 1), PREAMBLE_BYTE);
        if (kind == 1) drive_byte(1'b1, 1'b0, 8'($urandom_range(0, 8'h54)));
        if (kind != 3) begin
            drive_byte(1'b1, 1'b0, SFD_BYTE);
            for (int i = 0; i < 10; i++) drive_byte(1'b1, 1'b0, 8'($urandom));
        end
        idle(6);
    endtask

    task automatic make_payload(input int n, input logic counting);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(counting ? 8'(i) : 8'($urandom));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n     = 1'b1;
        ddr_data    = 8'h00;
        ddr_control = 2'b00;
        #3 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_last, out_error, out_data} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_last, out_error, out_data});
        end
        repeat (3) @(negedge clock);
        tests_run++;
        if (frame_count !== 32'd0) begin
            tests_failed++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count);
        end
        tests_run++;
        if (error_count !== 32'd0) begin
            tests_failed++; $display("FAIL reset_error_count: got %0d expected 0", error_count);
        end
        tests_run++;
        if (debug_state !== IDLE) begin
            tests_failed++; $display("FAIL reset_state: got %0d expected %0d", debug_state, IDLE);
        end
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_good_frame();
        make_payload(64, 1'b1);
        send_frame(7, -1);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL good_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL good_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (frame_count !== 32'(exp_frames) || error_count !== 32'(exp_errors)) begin
            tests_failed++;
            $display("FAIL good_counters: got %0d/%0d expected %0d/%0d", frame_count, error_count, exp_frames, exp_errors);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_rx_error();
        make_payload(64, 1'b1);
        send_frame(7, 10);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL rxer_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL rxer_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (frame_count !== 32'(exp_frames) || error_count !== 32'(exp_errors)) begin
            tests_failed++;
            $display("FAIL rxer_counters: got %0d/%0d expected %0d/%0d", frame_count, error_count, exp_frames, exp_errors);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_short_and_empty();
        make_payload(20, 1'b0);
        send_frame(7, -1);
        make_payload(0, 1'b0);
        send_frame(7, -1);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL short_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL short_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (frame_count !== 32'(exp_frames) || error_count !== 32'(exp_errors)) begin
            tests_failed++;
            $display("FAIL short_counters: got %0d/%0d expected %0d/%0d", frame_count, error_count, exp_frames, exp_errors);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_truncation();
        make_payload(150, 1'b0);
        send_frame(7, -1);
        make_payload(MAX_B, 1'b0);
        send_frame(3, -1);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL trunc_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL trunc_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (frame_count !== 32'(exp_frames) || error_count !== 32'(exp_errors)) begin
            tests_failed++;
            $display("FAIL trunc_counters: got %0d/%0d expected %0d/%0d", frame_count, error_count, exp_frames, exp_errors);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int kind;
        int len;
        for (int f = 0; f < 14; f++) begin
            kind = $urandom_range(0, 4);
            if (kind >= 3 && f % 2 == 0) kind = 0;
            if (kind == 0 || kind == 4) begin
                case ($urandom_range(0, 3))
                    0:       len = $urandom_range(0, 2);
                    1:       len = $urandom_range(3, MIN_B - 1);
                    2:       len = $urandom_range(MIN_B, MAX_B);
                    default: len = $urandom_range(MAX_B + 1, 130);
                endcase
                make_payload(len, 1'b0);
                send_frame($urandom_range(1, 7), ($urandom_range(0, 2) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1);
            end else begin
                send_garbage(kind);
            end
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL rand_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL rand_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (frame_count !== 32'(exp_frames) || error_count !== 32'(exp_errors)) begin
            tests_failed++;
            $display("FAIL rand_counters: got %0d/%0d expected %0d/%0d", frame_count, error_count, exp_frames, exp_errors);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int bad_prefix;
        // Release while a frame is on the wire: its preamble/SFD must be ignored.
        reset_n    = 1'b0;
        exp_frames = 0;
        exp_errors = 0;
        drive_byte(1'b1, 1'b0, 8'h3C);
        drive_byte(1'b1, 1'b0, 8'hA7);
        reset_n = 1'b1;
        make_payload(70, 1'b0);
        frame_start(3);
        for (int i = 0; i < payload.size(); i++) drive_byte(1'b1, 1'b0, payload[i]);
        idle(8);
        tests_run++;
        if (obs_q.size() != 0 || frame_count !== 32'd0 || error_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL release_mid_frame: got beats=%0d counts=%0d/%0d expected 0/0/0", obs_q.size(), frame_count, error_count);
        end
        obs_q.delete();

        // Reset pulse in the middle of a streaming payload.
        make_payload(30, 1'b0);
        frame_start(7);
        for (int i = 0; i < payload.size(); i++) drive_byte(1'b1, 1'b0, payload[i]);
        @(posedge clock);
        #2;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_last, out_error, out_data} !== 11'd0 || frame_count !== 32'd0 || error_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_pulse_outputs: got %h counts=%0d/%0d expected 0", {out_valid, out_last, out_error, out_data}, frame_count, error_count);
        end
        idle(2);
        reset_n = 1'b1;
        idle(4);
        bad_prefix = 0;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i][9] !== 1'b0 || obs_q[i][7:0] !== payload[i]) bad_prefix++;
        tests_run++;
        if (obs_q.size() < 20 || bad_prefix != 0 || frame_count !== 32'd0 || error_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL aborted_frame: got beats=%0d bad=%0d counts=%0d/%0d expected >=20/0/0/0", obs_q.size(), bad_prefix, frame_count, error_count);
        end
        obs_q.delete();

        make_payload(70, 1'b0);
        send_frame(5, -1);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL after_reset_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL after_reset_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (frame_count !== 32'(exp_frames) || error_count !== 32'(exp_errors)) begin
            tests_failed++;
            $display("FAIL after_reset_counters: got %0d/%0d expected %0d/%0d", frame_count, error_count, exp_frames, exp_errors);
        end
        obs_q.delete(); exp_q.delete();

        tests_run++;
        if (stray != 0) begin
            tests_failed++; $display("FAIL stray_flags: got %0d expected 0", stray);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_rx_error();
        test_short_and_empty();
        test_truncation();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
